// File: rtl/ddr_cmd_issuer.sv
// DDR4 command issuer: tracks the open row of every bank and sequences PR/ACT/RD/WR under tRCD/tRP/tRAS/tCCD.
// Define REFRESH_EN to build the periodic refresh scheduler (PR-all, REF, tRFC wait).
module ddr_cmd_issuer #(
   parameter int ADDRWIDTH     = 17,
   parameter int BANKGROUPS    = 1,
   parameter int BANKSPERGROUP = 8,
   parameter int ROWS          = 512,
   parameter int COLUMNS       = 512,
   parameter int TRCD          = 4,
   parameter int TRP           = 4,
   parameter int TRAS          = 10,
   parameter int TCCD          = 2,
   parameter int TREFI         = 780,
   parameter int TRFC          = 26,
   localparam int BGWIDTH = $clog2(BANKGROUPS),
   localparam int BAWIDTH = $clog2(BANKSPERGROUP),
   localparam int ROWW    = $clog2(ROWS),
   localparam int COLW    = $clog2(COLUMNS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [BGWIDTH:0]     req_bg,
   input  logic [BAWIDTH:0]     req_ba,
   input  logic [ROWW-1:0]      req_row,
   input  logic [COLW-1:0]      req_col,
   output logic                 reset_n,
   output logic                 cke,
   output logic                 cs_n,
   output logic                 act_n,
   output logic [ADDRWIDTH-1:0] addr,
   output logic [BAWIDTH:0]     ba,
   output logic [BGWIDTH:0]     bg,
   output logic                 busy
);
   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int NB   = BANKGROUPS * BANKSPERGROUP;
   localparam int BIW  = (NB > 1) ? $clog2(NB) : 1;
   localparam int CMAX = imax(imax(imax(TRCD, TRP), imax(TRAS, TCCD)), imax(TRFC, TREFI));
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [3:0] OP_PR = 4'd3;
   localparam logic [3:0] OP_RD = 4'd4;
   localparam logic [3:0] OP_WR = 4'd6;
`ifdef REFRESH_EN
   localparam logic [3:0] OP_REF = 4'd5;
`endif

   typedef enum logic [3:0] {
      S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_RW
`ifdef REFRESH_EN
      , S_REF_PRA, S_REF_WAIT_RP, S_REF, S_REF_WAIT_RFC
`endif
   } state_t;

   typedef enum logic [2:0] {
      C_NOP, C_ACT, C_PRE, C_RD, C_WR
`ifdef REFRESH_EN
      , C_PREA, C_REF
`endif
   } cmd_t;

   function automatic logic [BIW-1:0] bank_idx(input logic [BGWIDTH:0] g, input logic [BAWIDTH:0] b);
      logic [31:0] flat;
      flat = 32'(g) * 32'(BANKSPERGROUP) + 32'(b);
      return BIW'(flat % 32'(NB));
   endfunction

   state_t               state_q, state_d;
   logic [CW-1:0]        wait_q, wait_d, tccd_q, tccd_d;
   logic [NB-1:0]        open_q, open_d;
   logic [ROWW-1:0]      row_tab_q [NB];
   logic [ROWW-1:0]      row_tab_d [NB];
   logic [CW-1:0]        tras_q [NB];
   logic [CW-1:0]        tras_d [NB];
   logic                 lat_wr_q, lat_wr_d;
   logic [BGWIDTH:0]     lat_bg_q, lat_bg_d;
   logic [BAWIDTH:0]     lat_ba_q, lat_ba_d;
   logic [ROWW-1:0]      lat_row_q, lat_row_d;
   logic [COLW-1:0]      lat_col_q, lat_col_d;
   logic                 reset_n_q, cke_q, cs_n_q, cs_n_d, act_n_q, act_n_d;
   logic [ADDRWIDTH-1:0] addr_q, addr_d;
   logic [BAWIDTH:0]     ba_pin_q, ba_pin_d;
   logic [BGWIDTH:0]     bg_pin_q, bg_pin_d;
   cmd_t                 cmd;
   logic                 ready_int, refresh_due;
   logic                 sel_wr;
   logic [BGWIDTH:0]     sel_bg;
   logic [BAWIDTH:0]     sel_ba;
   logic [ROWW-1:0]      sel_row;
   logic [COLW-1:0]      sel_col;
   logic [BIW-1:0]       sel_idx;
   logic                 bank_open, row_hit, tras_ok, tccd_ok;

   // In IDLE the live request drives decisions; afterwards the latched copy does.
   always_comb begin
      if (state_q == S_IDLE) begin
         sel_wr = req_write; sel_bg = req_bg; sel_ba = req_ba; sel_row = req_row; sel_col = req_col;
      end else begin
         sel_wr = lat_wr_q; sel_bg = lat_bg_q; sel_ba = lat_ba_q; sel_row = lat_row_q; sel_col = lat_col_q;
      end
   end

   assign sel_idx   = bank_idx(sel_bg, sel_ba);
   assign bank_open = open_q[sel_idx];
   assign row_hit   = bank_open && (row_tab_q[sel_idx] == sel_row);
   assign tras_ok   = (tras_q[sel_idx] == '0);
   assign tccd_ok   = (tccd_q == '0);

`ifdef REFRESH_EN
   logic [CW-1:0] ref_cnt_q, ref_cnt_d;
   logic          ref_due_q, ref_due_d;
   logic          any_open, all_tras_ok;

   assign refresh_due = ref_due_q;
   assign any_open    = |open_q;

   always_comb begin
      all_tras_ok = 1'b1;
      for (int i = 0; i < NB; i++) if (tras_q[i] != '0) all_tras_ok = 1'b0;
   end

   always_comb begin
      ref_cnt_d = ref_cnt_q;
      ref_due_d = ref_due_q;
      if (cmd == C_REF) begin
         ref_cnt_d = '0;
         ref_due_d = 1'b0;
      end else if (cke_q && !ref_due_q) begin
         if (ref_cnt_q == CW'(TREFI - 1)) ref_due_d = 1'b1;
         else                             ref_cnt_d = ref_cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ref_cnt_q <= '0;
         ref_due_q <= 1'b0;
      end else begin
         ref_cnt_q <= ref_cnt_d;
         ref_due_q <= ref_due_d;
      end
   end
`else
   assign refresh_due = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // Wait states hold for T-1 cycles, so they are entered with T-2 and skipped entirely when T == 1.
   always_comb begin
      state_d = state_q;
      wait_d  = (wait_q != '0) ? wait_q - CW'(1) : '0;
      case (state_q)
         S_IDLE: begin
            if (cke_q) begin
`ifdef REFRESH_EN
               if (refresh_due) state_d = any_open ? S_REF_PRA : S_REF;
               else
`endif
               if (req_valid) begin
                  if (row_hit)        state_d = tccd_ok ? S_IDLE : S_RW;
                  else if (bank_open) state_d = S_PRE;
                  else                state_d = S_ACT;
               end
            end
         end
         S_PRE: if (tras_ok) begin
            state_d = (TRP > 1) ? S_WAIT_RP : S_ACT;
            wait_d  = CW'(TRP - 2);
         end
         S_WAIT_RP:  if (wait_q == '0) state_d = S_ACT;
         S_ACT: begin
            state_d = (TRCD > 1) ? S_WAIT_RCD : S_RW;
            wait_d  = CW'(TRCD - 2);
         end
         S_WAIT_RCD: if (wait_q == '0) state_d = S_RW;
         S_RW:       if (tccd_ok) state_d = S_IDLE;
`ifdef REFRESH_EN
         S_REF_PRA: if (all_tras_ok) begin
            state_d = (TRP > 1) ? S_REF_WAIT_RP : S_REF;
            wait_d  = CW'(TRP - 2);
         end
         S_REF_WAIT_RP: if (wait_q == '0) state_d = S_REF;
         S_REF: begin
            state_d = (TRFC > 1) ? S_REF_WAIT_RFC : S_IDLE;
            wait_d  = CW'(TRFC - 2);
         end
         S_REF_WAIT_RFC: if (wait_q == '0) state_d = S_IDLE;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cmd       = C_NOP;
      ready_int = 1'b0;
      case (state_q)
         S_IDLE: if (cke_q && !refresh_due && req_valid && row_hit && tccd_ok) begin
            cmd       = sel_wr ? C_WR : C_RD;
            ready_int = 1'b1;
         end
         S_PRE: if (tras_ok) cmd = C_PRE;
         S_ACT: cmd = C_ACT;
         S_RW: if (tccd_ok) begin
            cmd       = sel_wr ? C_WR : C_RD;
            ready_int = 1'b1;
         end
`ifdef REFRESH_EN
         S_REF_PRA: if (all_tras_ok) cmd = C_PREA;
         S_REF:     cmd = C_REF;
`endif
         default: cmd = C_NOP;
      endcase
   end

   always_comb begin
      open_d    = open_q;
      row_tab_d = row_tab_q;
      tccd_d    = tccd_ok ? '0 : tccd_q - CW'(1);
      for (int i = 0; i < NB; i++) tras_d[i] = (tras_q[i] != '0) ? tras_q[i] - CW'(1) : '0;
      lat_wr_d = lat_wr_q; lat_bg_d = lat_bg_q; lat_ba_d = lat_ba_q; lat_row_d = lat_row_q; lat_col_d = lat_col_q;
      if (state_q == S_IDLE) begin
         lat_wr_d = req_write; lat_bg_d = req_bg; lat_ba_d = req_ba; lat_row_d = req_row; lat_col_d = req_col;
      end
      case (cmd)
         C_ACT: begin
            open_d[sel_idx]    = 1'b1;
            row_tab_d[sel_idx] = sel_row;
            tras_d[sel_idx]    = CW'(TRAS - 1);
         end
         C_PRE:       open_d[sel_idx] = 1'b0;
         C_RD, C_WR:  tccd_d = CW'(TCCD - 1);
`ifdef REFRESH_EN
         C_PREA:      open_d = '0;
`endif
         default: ;
      endcase
   end

   always_comb begin
      cs_n_d   = 1'b1;
      act_n_d  = 1'b1;
      addr_d   = '0;
      ba_pin_d = '0;
      bg_pin_d = '0;
      case (cmd)
         C_ACT: begin
            cs_n_d = 1'b0; act_n_d = 1'b0; addr_d[ROWW-1:0] = sel_row;
            ba_pin_d = sel_ba; bg_pin_d = sel_bg;
         end
         C_PRE: begin
            cs_n_d = 1'b0; addr_d[ADDRWIDTH-1 -: 4] = OP_PR;
            ba_pin_d = sel_ba; bg_pin_d = sel_bg;
         end
         C_RD, C_WR: begin
            cs_n_d = 1'b0; addr_d[ADDRWIDTH-1 -: 4] = (cmd == C_WR) ? OP_WR : OP_RD;
            addr_d[COLW-1:0] = sel_col; ba_pin_d = sel_ba; bg_pin_d = sel_bg;
         end
`ifdef REFRESH_EN
         C_PREA: begin
            cs_n_d = 1'b0; addr_d[ADDRWIDTH-1 -: 4] = OP_PR; addr_d[10] = 1'b1;
         end
         C_REF: begin
            cs_n_d = 1'b0; addr_d[ADDRWIDTH-1 -: 4] = OP_REF;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         open_q    <= '0;
         tccd_q    <= '0;
         for (int i = 0; i < NB; i++) begin
            row_tab_q[i] <= '0;
            tras_q[i]    <= '0;
         end
         lat_wr_q  <= 1'b0; lat_bg_q <= '0; lat_ba_q <= '0; lat_row_q <= '0; lat_col_q <= '0;
         reset_n_q <= 1'b0; cke_q    <= 1'b0;
         cs_n_q    <= 1'b1; act_n_q  <= 1'b1; addr_q   <= '0; ba_pin_q  <= '0; bg_pin_q  <= '0;
      end else begin
         open_q    <= open_d;
         tccd_q    <= tccd_d;
         row_tab_q <= row_tab_d;
         tras_q    <= tras_d;
         lat_wr_q  <= lat_wr_d; lat_bg_q <= lat_bg_d; lat_ba_q <= lat_ba_d;
         lat_row_q <= lat_row_d; lat_col_q <= lat_col_d;
         reset_n_q <= 1'b1;
         cke_q     <= reset_n_q;
         cs_n_q    <= cs_n_d; act_n_q <= act_n_d; addr_q <= addr_d;
         ba_pin_q  <= ba_pin_d; bg_pin_q <= bg_pin_d;
      end
   end

   assign req_ready = ready_int;
   assign busy      = (state_q != S_IDLE);
   assign reset_n   = reset_n_q;
   assign cke       = cke_q;
   assign cs_n      = cs_n_q;
   assign act_n     = act_n_q;
   assign addr      = addr_q;
   assign ba        = ba_pin_q;
   assign bg        = bg_pin_q;
endmodule

// File: tb/tb_ddr_cmd_issuer.sv
// Directed bench for ddr_cmd_issuer: reset release, closed/hit/miss request table, async reset mid-sequence,
// and idle behaviour (refresh sequence when REFRESH_EN is defined).
module tb_ddr_cmd_issuer;
   localparam int TRCD = 4, TRP = 4, TRAS = 10, TCCD = 2, TRFC = 26;
   localparam int K_HIT = 0, K_CLOSED = 1, K_MISS = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_write = 1'b0;
   logic [0:0]  req_bg = '0;
   logic [3:0]  req_ba = '0;
   logic [8:0]  req_row = '0, req_col = '0;
   logic        req_ready, reset_n, cke, cs_n, act_n, busy;
   logic [16:0] addr;
   logic [3:0]  ba;
   logic [0:0]  bg;

   ddr_cmd_issuer dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
      .reset_n(reset_n), .cke(cke), .cs_n(cs_n), .act_n(act_n), .addr(addr), .ba(ba), .bg(bg), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          c;
      logic        act_n;
      logic [3:0]  ba;
      logic [16:0] addr;
   } cmd_rec_t;

   typedef struct {
      logic       wr;
      logic [3:0] ba;
      logic [8:0] row;
      logic [8:0] col;
      int         kind;
      int         rw_gap;
   } req_t;

   int          cyc = 0;
   cmd_rec_t    cmd_q[$];
   logic [21:0] exp_q[$];
   int          total = 0, bad = 0;
   int          last_act[16];
   int          last_rw;
   req_t        tbl[9];

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #1;
      if (cs_n === 1'b0) cmd_q.push_back('{cyc, act_n, ba, addr});
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic check_ge(input string name, input int act, input int min);
      total++;
      if (act < min) begin
         bad++;
         $display("FAIL %s: got %0d want >= %0d", name, act, min);
      end
   endtask

   function automatic logic [21:0] w_act(input logic [3:0] b, input logic [8:0] r);
      return {1'b0, b, 8'd0, r};
   endfunction
   function automatic logic [21:0] w_pr(input logic [3:0] b);
      return {1'b1, b, 4'd3, 13'd0};
   endfunction
   function automatic logic [21:0] w_rw(input logic w, input logic [3:0] b, input logic [8:0] c);
      return {1'b1, b, (w ? 4'd6 : 4'd4), 4'd0, c};
   endfunction

   task automatic reset_history();
      for (int i = 0; i < 16; i++) last_act[i] = -1000;
      last_rw = -1000;
   endtask

   // Called right after a negedge; returns at a negedge with req_valid low.
   task automatic send(input req_t r);
      bit acc;
      int n;
      acc = 0; n = 0;
      req_write = r.wr; req_bg = '0; req_ba = r.ba; req_row = r.row; req_col = r.col;
      req_valid = 1'b1;
      while (!acc && n < 100) begin
         #1;
         if (req_ready === 1'b1) acc = 1;
         else begin
            @(negedge clk);
            n++;
         end
      end
      check("accept", 32'(acc), 32'd1);
      if (acc) @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic check_req(input req_t r);
      cmd_rec_t c;
      int ncmd, nexp, rwc;
      int cs[4];
      exp_q.delete();
      if (r.kind == K_MISS) exp_q.push_back(w_pr(r.ba));
      if (r.kind != K_HIT)  exp_q.push_back(w_act(r.ba, r.row));
      exp_q.push_back(w_rw(r.wr, r.ba, r.col));
      ncmd = cmd_q.size();
      nexp = exp_q.size();
      check("ncmd", ncmd, nexp);
      for (int i = 0; i < 4; i++) cs[i] = 0;
      for (int i = 0; i < nexp && cmd_q.size() > 0; i++) begin
         c = cmd_q.pop_front();
         cs[i] = c.c;
         check("cmd", {c.act_n, c.ba, c.addr}, exp_q.pop_front());
      end
      cmd_q.delete();
      exp_q.delete();
      if (ncmd == nexp) begin
         rwc = cs[nexp-1];
         if (r.kind == K_MISS) begin
            check_ge("tras", cs[0] - last_act[r.ba], TRAS);
            check("trp", cs[1] - cs[0], TRP);
         end
         if (r.kind != K_HIT) begin
            check("trcd", rwc - cs[nexp-2], TRCD);
            last_act[r.ba] = cs[nexp-2];
         end
         if (r.rw_gap != 0) check("tccd_gap", rwc - last_rw, r.rw_gap);
         else               check_ge("tccd_min", rwc - last_rw, TCCD);
         last_rw = rwc;
      end
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("rel1_pins", {reset_n, cke, cs_n, req_ready, busy}, {1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
      @(posedge clk); #1;
      check("rel2_pins", {reset_n, cke, cs_n, req_ready, busy}, {1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
      @(negedge clk);
   endtask

   initial begin
      req_t     mid;
      cmd_rec_t c;
      int       n;
      tbl[0] = '{1'b0, 4'd2, 9'd5,   9'd7,   K_CLOSED, 0};
      tbl[1] = '{1'b0, 4'd2, 9'd5,   9'd8,   K_HIT,    2};
      tbl[2] = '{1'b0, 4'd2, 9'd5,   9'd9,   K_HIT,    2};
      tbl[3] = '{1'b1, 4'd2, 9'd9,   9'd3,   K_MISS,   0};
      tbl[4] = '{1'b0, 4'd3, 9'd1,   9'd1,   K_CLOSED, 0};
      tbl[5] = '{1'b1, 4'd2, 9'd9,   9'd4,   K_HIT,    2};
      tbl[6] = '{1'b0, 4'd3, 9'd7,   9'd2,   K_MISS,   0};
      tbl[7] = '{1'b0, 4'd0, 9'd511, 9'd511, K_CLOSED, 0};
      tbl[8] = '{1'b1, 4'd0, 9'd511, 9'd0,   K_HIT,    2};
      mid    = '{1'b0, 4'd5, 9'd3,   9'd6,   K_CLOSED, 0};
      reset_history();

      repeat (3) @(negedge clk);
      #1;
      check("rst_pins", {reset_n, cke, cs_n, act_n, addr, ba, bg, req_ready, busy},
            {1'b0, 1'b0, 1'b1, 1'b1, 17'd0, 4'd0, 1'b0, 1'b0, 1'b0});
      release_reset();
      check("no_cmd_after_release", cmd_q.size(), 0);

      for (int i = 0; i < 9; i++) begin
         send(tbl[i]);
         check_req(tbl[i]);
      end

      // Async reset while waiting tRCD after an ACT; the open-row table must be forgotten.
      req_write = mid.wr; req_bg = '0; req_ba = mid.ba; req_row = mid.row; req_col = mid.col;
      req_valid = 1'b1;
      n = 0;
      while (cmd_q.size() == 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("mid_act_seen", cmd_q.size(), 1);
      if (cmd_q.size() > 0) begin
         c = cmd_q.pop_front();
         check("mid_act", {c.act_n, c.ba, c.addr}, w_act(mid.ba, mid.row));
      end
      #2 rst = 1'b1;
      #1;
      check("async_rst_pins", {reset_n, cke, cs_n, act_n, addr, ba, bg, req_ready, busy},
            {1'b0, 1'b0, 1'b1, 1'b1, 17'd0, 4'd0, 1'b0, 1'b0, 1'b0});
      repeat (2) @(negedge clk);
      cmd_q.delete();
      reset_history();
      release_reset();
      send(mid);
      check_req(mid);

`ifdef REFRESH_EN
      rst = 1'b1;
      repeat (2) @(negedge clk);
      cmd_q.delete();
      reset_history();
      release_reset();
      send(tbl[0]);
      check_req(tbl[0]);
      n = 0;
      while (cmd_q.size() == 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("pra_seen", 32'(cmd_q.size() > 0), 32'd1);
      if (cmd_q.size() > 0) begin
         c = cmd_q.pop_front();
         check("pra", {c.act_n, c.ba, c.addr}, {1'b1, 4'd0, 4'd3, 2'b00, 1'b1, 10'd0});
         n = c.c;
         repeat (TRP + 1) @(negedge clk);
         check("ref_seen", cmd_q.size(), 1);
         if (cmd_q.size() > 0) begin
            c = cmd_q.pop_front();
            check("ref", {c.act_n, c.ba, c.addr}, {1'b1, 4'd0, 4'd5, 13'd0});
            check("ref_gap", c.c - n, TRP);
         end
      end
      req_write = tbl[0].wr; req_ba = tbl[0].ba; req_row = tbl[0].row; req_col = tbl[0].col;
      req_valid = 1'b1;
      n = 0;
      repeat (TRFC - 8) begin
         @(negedge clk); #1;
         if (req_ready === 1'b1) n++;
      end
      check("rfc_ready_low", n, 0);
      @(negedge clk);
      cmd_q.delete();
      send(tbl[0]);
      check_req(tbl[0]);
`else
      cmd_q.delete();
      repeat (2000) @(negedge clk);
      check("idle_no_cmd", cmd_q.size(), 0);
      check("idle_busy", {busy, req_ready}, 2'b00);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
